// File: rtl/seg7_result_display_pkg.sv
// Shared types and constants for the signed-result seven-segment display.
package seg7_result_display_pkg;

    localparam int W    = 16;  // signed input width
    localparam int NDIG = 5;   // BCD digits, enough for magnitude 32768

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Segment codes, bit order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // BCD digit to segment pattern; non-decimal codes show blank
    function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per clock, W clocks per result.
// Handshake: start is honoured only while busy=0 and launches a conversion;
// done is high for exactly the cycle whose rising edge completes the final
// step, and bcd carries the finished result only during that cycle.
module bin2bcd_seq #(
    parameter int W    = seg7_result_display_pkg::W,
    parameter int NDIG = seg7_result_display_pkg::NDIG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W-1:0]      bin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] bcd
);
    import seg7_result_display_pkg::*;

    localparam int CW = $clog2(W);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]      bin_q, bin_d;
    logic [4*NDIG-1:0] bcd_q, bcd_d;
    logic [4*NDIG-1:0] adj;

    // Add-3 correction on every digit that would overflow when doubled
    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < NDIG; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Next-state: load on start, then correct-and-shift one bit per cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                {bcd_d, bin_d} = {adj[4*NDIG-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single state register; reset aborts any conversion in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = (state_q == CONV);
    assign bcd  = bcd_d;

endmodule

// File: rtl/seg7_result_display.sv
// Signed result display: captures a two's-complement value, converts its
// magnitude to BCD and multiplexes a 4-digit window of {sign, d4..d0} onto
// an active-low common-anode display.
module seg7_result_display #(
    parameter int W    = seg7_result_display_pkg::W,
    parameter int NDIG = seg7_result_display_pkg::NDIG
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic [1:0]   win,
    output logic         busy,
    output logic         valid,
    output logic [3:0]   anode,
    output logic [6:0]   seg
);
    import seg7_result_display_pkg::*;

    logic              start;
    logic [W-1:0]      mag;
    logic              conv_busy;
    logic              conv_done;
    logic [4*NDIG-1:0] conv_bcd;

    logic              sign_pend_q, sign_pend_d;
    logic              sign_q, sign_d;
    logic              valid_q, valid_d;
    logic [4*NDIG-1:0] digits_q, digits_d;
    logic [1:0]        p_q, p_d;
    logic [3:0]        anode_q, anode_d;
    logic [6:0]        seg_q, seg_d;

    logic [1:0]        win_eff;
    logic [2:0]        sym_idx;
    logic [6:0]        sym [8];
    logic              zero_run;

    // A load arriving mid-conversion is dropped
    assign start = load & ~conv_busy;

    // Magnitude as unsigned W bits, so the most negative value maps to 2^(W-1)
    always_comb begin
        mag = value[W-1] ? (~value + 1'b1) : value;
    end

    bin2bcd_seq #(
        .W    (W),
        .NDIG (NDIG)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (mag),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Build the symbol string with leading-zero blanking; d0 always shows
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            sym[i] = SEG_BLANK;
        end
        zero_run = 1'b1;
        for (int k = NDIG - 1; k >= 0; k--) begin
            zero_run = zero_run & (digits_q[4*k +: 4] == 4'd0);
            if (zero_run && (k != 0)) begin
                sym[k] = SEG_BLANK;
            end else begin
                sym[k] = seg_of_digit(digits_q[4*k +: 4]);
            end
        end
        sym[NDIG] = sign_q ? SEG_MINUS : SEG_BLANK;
    end

    // Display data, scan position and registered anode/segment drive
    always_comb begin
        sign_pend_d = start ? value[W-1] : sign_pend_q;
        digits_d    = conv_done ? conv_bcd : digits_q;
        sign_d      = conv_done ? sign_pend_q : sign_q;
        valid_d     = valid_q | conv_done;
        p_d         = tick ? (p_q + 2'd1) : p_q;
        win_eff     = (win == 2'd3) ? 2'd2 : win;
        sym_idx     = 3'(win_eff) + 3'(p_q);
        anode_d     = ~(4'b0001 << p_q);
        seg_d       = valid_q ? sym[sym_idx] : SEG_BLANK;
    end

    // Display registers; reset wins over load and tick
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_pend_q <= 1'b0;
            sign_q      <= 1'b0;
            valid_q     <= 1'b0;
            digits_q    <= '0;
            p_q         <= 2'd0;
            anode_q     <= 4'b1110;
            seg_q       <= SEG_BLANK;
        end else begin
            sign_pend_q <= sign_pend_d;
            sign_q      <= sign_d;
            valid_q     <= valid_d;
            digits_q    <= digits_d;
            p_q         <= p_d;
            anode_q     <= anode_d;
            seg_q       <= seg_d;
        end
    end

    assign busy  = conv_busy;
    assign valid = valid_q;
    assign anode = anode_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_seg7_result_display.sv
// Bench for seg7_result_display: table of converted values with their
// expected scan patterns, plus hand-written reset/load/tick corner sequences.
module tb_seg7_result_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] SM = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  typedef struct packed {
    logic [15:0] value;
    logic [1:0]  win;
    logic [27:0] exp;   // {pos3, pos2, pos1, pos0}
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, tick, load;
  logic [15:0] value;
  logic [1:0]  win;
  logic        busy, valid;
  logic [3:0]  anode;
  logic [6:0]  seg;

  int n_cmp = 0;
  int n_bad = 0;
  int p_model = 0;
  int n;
  vec_t vecs[7];

  seg7_result_display dut (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .load  (load),
    .value (value),
    .win   (win),
    .busy  (busy),
    .valid (valid),
    .anode (anode),
    .seg   (seg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [27:0] pk(input logic [6:0] a, input logic [6:0] b,
                                     input logic [6:0] c, input logic [6:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse load and count cycles with busy high (bounded)
  task automatic convert(input logic [15:0] v, output int cnt);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
    cnt   = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
  endtask

  // Tick four times, checking each scan position one clock after the tick
  task automatic scan_check(input int id, input logic [27:0] exp);
    logic [3:0] exp_an;
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      p_model = (p_model + 1) % 4;
      step();
      exp_an = ~(4'b0001 << p_model);
      chk($sformatf("v%0d anode p%0d", id, p_model), 32'(anode), 32'(exp_an));
      chk($sformatf("v%0d seg p%0d", id, p_model), 32'(seg), 32'(exp[p_model*7 +: 7]));
    end
  endtask

  initial begin
    vecs[0] = '{16'd1234,  2'd0, pk(S4, S3, S2, S1)};
    vecs[1] = '{16'h8000,  2'd2, pk(S7, S2, S3, SM)};
    vecs[2] = '{16'hFFFB,  2'd0, pk(S5, SB, SB, SB)};
    vecs[3] = '{16'hFFFB,  2'd2, pk(SB, SB, SB, SM)};
    vecs[4] = '{16'h7FFF,  2'd3, pk(S7, S2, S3, SB)};
    vecs[5] = '{16'd1000,  2'd1, pk(S0, S0, S1, SB)};
    vecs[6] = '{16'hFFF6,  2'd0, pk(S0, S1, SB, SB)};

    rst = 1'b1; tick = 1'b0; load = 1'b0; value = '0; win = 2'd0;
    step();
    step();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset anode", 32'(anode), 32'hE);
    chk("reset seg", 32'(seg), 32'(SB));
    rst = 1'b0;
    p_model = 0;

    // scanning continues while nothing is valid, segments blank
    tick = 1'b1; step(); tick = 1'b0; p_model = 1; step();
    chk("invalid anode", 32'(anode), 32'hD);
    chk("invalid seg", 32'(seg), 32'(SB));

    // table-driven conversions
    for (int v = 0; v < 7; v++) begin
      win = vecs[v].win;
      convert(vecs[v].value, n);
      chk($sformatf("v%0d busy cycles", v), 32'(n), 32'd16);
      chk($sformatf("v%0d valid", v), 32'(valid), 32'd1);
      scan_check(v, vecs[v].exp);
    end

    // load during busy is ignored
    win = 2'd0;
    value = 16'd100; load = 1'b1; step(); load = 1'b0;
    n = 0;
    repeat (4) begin
      if (busy) n++;
      step();
    end
    value = 16'd999; load = 1'b1;
    if (busy) n++;
    step();
    load = 1'b0;
    chk("old valid held during busy", 32'(valid), 32'd1);
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("ignored load busy cycles", 32'(n), 32'd16);
    step();
    chk("ignored load no restart", 32'(busy), 32'd0);
    scan_check(10, pk(S0, S0, S1, SB));

    // reset mid-conversion aborts and blanks
    value = 16'd555; load = 1'b1; step(); load = 1'b0;
    repeat (7) step();
    chk("pre-abort busy", 32'(busy), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    p_model = 0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort valid", 32'(valid), 32'd0);
    chk("abort anode", 32'(anode), 32'hE);
    chk("abort seg", 32'(seg), 32'(SB));
    repeat (20) step();
    chk("abort valid stays low", 32'(valid), 32'd0);
    chk("abort seg stays blank", 32'(seg), 32'(SB));
    win = 2'd0;
    convert(16'd0, n);
    chk("zero busy cycles", 32'(n), 32'd16);
    scan_check(11, pk(S0, SB, SB, SB));

    // tick and load in the same cycle
    value = 16'd42; tick = 1'b1; load = 1'b1;
    step();
    tick = 1'b0; load = 1'b0;
    p_model = (p_model + 1) % 4;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("tick+load busy cycles", 32'(n), 32'd16);
    chk("tick+load anode", 32'(anode), 32'(~(4'b0001 << p_model) & 4'hF));
    scan_check(12, pk(S2, S4, SB, SB));

    // reset beats load and tick
    value = 16'd7; rst = 1'b1; load = 1'b1; tick = 1'b1;
    step();
    rst = 1'b0; load = 1'b0; tick = 1'b0;
    p_model = 0;
    chk("rst prio busy", 32'(busy), 32'd0);
    chk("rst prio valid", 32'(valid), 32'd0);
    chk("rst prio anode", 32'(anode), 32'hE);
    chk("rst prio seg", 32'(seg), 32'(SB));
    step();
    chk("rst prio no conversion", 32'(busy), 32'd0);
    chk("rst prio anode hold", 32'(anode), 32'hE);

    // a fresh value after reset: 6 on position 0
    convert(16'hFFFA, n);
    chk("minus six busy cycles", 32'(n), 32'd16);
    win = 2'd2;
    scan_check(13, pk(SB, SB, SB, SM));
    win = 2'd0;
    scan_check(14, pk(S6, SB, SB, SB));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_result_display.md
SEG7_RESULT_DISPLAY -- requirements
Module: seg7_result_display

Interface
REQ-001 Parameter: W, 16, width of the signed input value.
REQ-002 Parameter: NDIG, 5, number of BCD digits produced (covers 0..32768).
REQ-003 Port: clk  in  1  single system clock; all logic on its rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: tick  in  1  refresh enable, one clk-wide pulse per digit period (divider output, ~2.5 ms).
REQ-006 Port: load  in  1  capture request for value.
REQ-007 Port: value  in  W  signed two's-complement multiplier result.
REQ-008 Port: win  in  2  display window start (0..2; 3 is treated as 2).
REQ-009 Port: busy  out  1  conversion in progress.
REQ-010 Port: valid  out  1  display holds a converted result.
REQ-011 Port: anode  out  4  digit enables, active-low, one-hot.
REQ-012 Port: seg  out  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-013 FSM states SHALL be IDLE and CONV only.
REQ-014 In IDLE, load=1 at edge E0 SHALL capture sign=value[W-1] and magnitude=(~value+1) if negative else value, as W-bit unsigned (-32768 -> 32768), and go to CONV.
REQ-015 CONV SHALL run sequential double-dabble (add-3 then shift), one bit per edge, at edges E1..E16.
REQ-016 busy SHALL be 1 exactly from after E0 through E16 (16 cycles).
REQ-017 At E16 the display digit registers d4..d0 and sign SHALL update, valid SHALL go to 1, and the FSM SHALL return to IDLE.
REQ-018 load while busy=1 SHALL be ignored; displayed data SHALL stay unchanged until the next conversion completes.
REQ-019 Symbol string: S0=d0 ... S4=d4, S5=sign symbol (minus if negative, blank otherwise).
REQ-020 Leading-zero blanking: each of d4..d1 SHALL show blank when it and all higher digits are 0; d0 SHALL always show.
REQ-021 Scan index p (2-bit) SHALL increment on each tick, wrapping 3->0; anode bit p low, others high.
REQ-022 Position p SHALL show S[min(win,2)+p].
REQ-023 anode and seg SHALL be registered, changing one clk after the tick edge that advanced p.
REQ-024 While valid=0, seg SHALL be 1111111 (blank), scanning continuing.
REQ-025 Encoding (gfedcba, active-low): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 minus=0111111 blank=1111111.
REQ-026 tick and load in the same cycle SHALL both take effect independently.
REQ-027 A win change SHALL take effect at the next seg update.

Reset
REQ-028 rst=1 SHALL force IDLE, busy=0, valid=0, p=0, anode=1110, seg=1111111, digits=0, sign=0, within one edge.
REQ-029 rst during CONV SHALL abort the conversion; the partial result SHALL never be displayed.
REQ-030 rst SHALL take precedence over load and tick in the same cycle.

Structure
REQ-031 Shared package SHALL hold: state enum, W, NDIG, the 12 segment codes, the blank/minus constants.
REQ-032 Double-dabble engine SHALL be a sub-module bin2bcd_seq (start, bin in, busy, done, bcd out); scan/decode in top level.

Verification
REQ-033 load value=1234, win=0 -> busy high 16 cycles, valid=1; over 4 ticks anode 1110/1101/1011/0111 with seg 4/3/2/1 codes.
REQ-034 load value=-32768, win=2 -> positions 0..3 show 7,2,3,minus (0011001? no: 1111000,0100100,0110000,0111111).
REQ-035 load value=-5, win=0 -> positions show 5,blank,blank,blank; win=2 -> blank,blank,blank,minus.
REQ-036 load 100, then load 999 at busy cycle 5 -> second load ignored; display 0,0,1,blank (win=0).
REQ-037 rst at busy cycle 8 -> busy=0, valid=0, seg blank next edge; then load 0 -> position 0 shows 1000000, others blank.
REQ-038 tick coincident with load -> p advances and conversion starts in the same cycle; no tick lost.
